// File: rtl/paddle_ctrl_filtered.sv
// Paddle controller: 4-tap averaged accelerometer input drives paddle_y through
// dead/slow/fast zones with a speed ramp, saturating clamps and a button mode.
module paddle_ctrl_filtered #(
  parameter int unsigned X_POS       = 778,
  parameter int unsigned Y_INIT      = 200,
  parameter int unsigned Y_MIN       = 2,
  parameter int unsigned Y_MAX       = 470,
  parameter int unsigned TH_UP_FAST  = 120,
  parameter int unsigned TH_UP       = 230,
  parameter int unsigned TH_DN       = 270,
  parameter int unsigned TH_DN_FAST  = 380,
  parameter int unsigned ACL_MAX     = 550,
  parameter int unsigned V_SLOW      = 1,
  parameter int unsigned V_FAST      = 2,
  parameter int unsigned V_MAX       = 4,
  parameter int unsigned RAMP_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        win_rst,
  input  logic        frame,
  input  logic [9:0]  ACL_IN,
  input  logic        mode,
  input  logic        btn_up,
  input  logic        btn_dn,
  output logic [10:0] paddle_x,
  output logic [9:0]  paddle_y,
  output logic [1:0]  dir,
  output logic [2:0]  speed,
  output logic        at_top,
  output logic        at_bot
);

  localparam int unsigned AW = 10;
  localparam int unsigned SW = 12;
  localparam int unsigned YW = 10;
  localparam int unsigned XW = 11;
  localparam int unsigned VW = 3;
  localparam int unsigned CW = $clog2(RAMP_FRAMES + 1);

  localparam logic [1:0]    DIR_IDLE = 2'b00;
  localparam logic [1:0]    DIR_UP   = 2'b01;
  localparam logic [1:0]    DIR_DN   = 2'b10;
  localparam logic [AW-1:0] TAP_INIT = AW'((TH_UP + TH_DN) / 2);

  logic [AW-1:0] taps_q [4];
  logic [AW-1:0] taps_d [4];
  logic [AW-1:0] avg_q, avg_d;
  logic [SW-1:0] sum_d;
  logic          pending_q, pending_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    dir_q, dir_d;
  logic [VW-1:0] speed_q, speed_d;
  logic          at_top_q, at_bot_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] fstep_q, fstep_d;
  logic          last_fast_q, last_fast_d;

  logic          srst;
  logic          sample_ok;
  logic [1:0]    zone_dir;
  logic          zone_fast;
  logic          same_run;
  logic [VW-1:0] step_cur;
  logic [VW-1:0] applied;
  logic [CW-1:0] cnt_inc;
  logic [XW-1:0] y_ext, step_ext;

  assign srst      = !rst || win_rst;
  assign sample_ok = (ACL_IN <= AW'(ACL_MAX));

  // State register
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 4; i++) taps_q[i] <= TAP_INIT;
      avg_q       <= TAP_INIT;
      pending_q   <= 1'b0;
      y_q         <= YW'(Y_INIT);
      dir_q       <= DIR_IDLE;
      speed_q     <= '0;
      at_top_q    <= (YW'(Y_INIT) == YW'(Y_MIN));
      at_bot_q    <= (YW'(Y_INIT) == YW'(Y_MAX));
      cnt_q       <= '0;
      fstep_q     <= VW'(V_FAST);
      last_fast_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) taps_q[i] <= taps_d[i];
      avg_q       <= avg_d;
      pending_q   <= pending_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      speed_q     <= speed_d;
      at_top_q    <= (y_d == YW'(Y_MIN));
      at_bot_q    <= (y_d == YW'(Y_MAX));
      cnt_q       <= cnt_d;
      fstep_q     <= fstep_d;
      last_fast_q <= last_fast_d;
    end
  end

  // Filter window: invalid samples leave the window (and so the average) untouched
  always_comb begin
    for (int i = 0; i < 4; i++) taps_d[i] = taps_q[i];
    if (frame && sample_ok) begin
      taps_d[0] = ACL_IN;
      for (int i = 1; i < 4; i++) taps_d[i] = taps_q[i-1];
    end
    sum_d     = SW'(taps_d[0]) + SW'(taps_d[1]) + SW'(taps_d[2]) + SW'(taps_d[3]);
    avg_d     = AW'(sum_d >> 2);
    pending_d = frame;
  end

  // Zone decision from the registered average, or from the buttons in manual mode
  always_comb begin
    zone_dir  = DIR_IDLE;
    zone_fast = 1'b0;
    if (mode) begin
      if (btn_up ^ btn_dn) zone_dir = btn_up ? DIR_UP : DIR_DN;
    end else if (avg_q <= AW'(TH_UP_FAST)) begin
      zone_dir  = DIR_UP;
      zone_fast = 1'b1;
    end else if (avg_q <= AW'(TH_UP)) begin
      zone_dir  = DIR_UP;
    end else if (avg_q < AW'(TH_DN)) begin
      zone_dir  = DIR_IDLE;
    end else if (avg_q < AW'(TH_DN_FAST)) begin
      zone_dir  = DIR_DN;
    end else begin
      zone_dir  = DIR_DN;
      zone_fast = 1'b1;
    end
  end

  // Ramp and position update, applied one cycle after the frame tick
  always_comb begin
    same_run    = last_fast_q && (dir_q == zone_dir);
    step_cur    = same_run ? fstep_q : VW'(V_FAST);
    cnt_inc     = (same_run ? cnt_q : CW'(0)) + CW'(1);
    applied     = VW'(0);
    y_d         = y_q;
    dir_d       = dir_q;
    speed_d     = speed_q;
    cnt_d       = cnt_q;
    fstep_d     = fstep_q;
    last_fast_d = last_fast_q;
    y_ext       = XW'(y_q);
    step_ext    = XW'(0);
    if (pending_q) begin
      if (zone_fast) begin
        applied     = step_cur;
        last_fast_d = 1'b1;
        if (cnt_inc == CW'(RAMP_FRAMES)) begin
          cnt_d   = CW'(0);
          fstep_d = (step_cur >= VW'(V_MAX)) ? VW'(V_MAX) : step_cur + VW'(1);
        end else begin
          cnt_d   = cnt_inc;
          fstep_d = step_cur;
        end
      end else begin
        applied     = (zone_dir == DIR_IDLE) ? VW'(0) : VW'(V_SLOW);
        last_fast_d = 1'b0;
        cnt_d       = CW'(0);
        fstep_d     = VW'(V_FAST);
      end
      step_ext = XW'(applied);
      dir_d    = zone_dir;
      speed_d  = applied;
      if (zone_dir == DIR_UP) begin
        if (y_ext < XW'(Y_MIN) + step_ext) y_d = YW'(Y_MIN);
        else                               y_d = YW'(y_ext - step_ext);
      end else if (zone_dir == DIR_DN) begin
        if (y_ext > XW'(Y_MAX) - step_ext) y_d = YW'(Y_MAX);
        else                               y_d = YW'(y_ext + step_ext);
      end
    end
  end

  assign paddle_x = XW'(X_POS);
  assign paddle_y = y_q;
  assign dir      = dir_q;
  assign speed    = speed_q;
  assign at_top   = at_top_q;
  assign at_bot   = at_bot_q;

endmodule
